// File: rtl/vga_pkg.sv
// Shared defaults and helpers for the VGA scanout block.
package vga_pkg;

  localparam int unsigned BPC_DEFAULT = 4;
  localparam int unsigned HW_DEFAULT  = 12;
  localparam int unsigned VW_DEFAULT  = 12;

  // Level driven on hsync/vsync during the sync pulse.
  localparam logic SYNC_ACTIVE = 1'b0;

  function automatic logic axis_cfg_ok(input int unsigned size, input int unsigned porch,
                                       input int unsigned synch, input int unsigned raw);
    return (size != 0) && (size < porch) && (porch < synch) && (synch < raw);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter with wrap, plus active/sync/last decode of the next position.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic         step,
  input  logic [W-1:0] raw,
  input  logic [W-1:0] dec_size,
  input  logic [W-1:0] dec_porch,
  input  logic [W-1:0] dec_synch,
  input  logic [W-1:0] dec_raw,
  output logic         last,
  output logic         active_nxt,
  output logic         sync_nxt,
  output logic         last_nxt
);

  logic [W-1:0] pos_q, pos_d;

  assign last = (pos_q == raw - 1'b1);

  always_comb begin
    pos_d = pos_q;
    if (!run) begin
      pos_d = '0;
    end else if (step) begin
      pos_d = last ? '0 : pos_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  // Decode against the config that will be in force when pos_d becomes current.
  assign active_nxt = (pos_d < dec_size);
  assign sync_nxt   = ((pos_d >= dec_porch) && (pos_d < dec_synch)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign last_nxt   = (pos_d == dec_raw - 1'b1);

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout timing generator with frame-latched config and a two-stage pixel pipeline.
// Define VGA_SCANOUT_DE_EN to add the o_vga_de data-enable output.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned BITS_PER_COLOR = BPC_DEFAULT,
  parameter int unsigned HW             = HW_DEFAULT,
  parameter int unsigned VW             = VW_DEFAULT
) (
  input  logic                        i_pixclk,
  input  logic                        i_reset,
  input  logic [HW-1:0]               i_hm_width,
  input  logic [HW-1:0]               i_hm_porch,
  input  logic [HW-1:0]               i_hm_synch,
  input  logic [HW-1:0]               i_hm_raw,
  input  logic [VW-1:0]               i_vm_height,
  input  logic [VW-1:0]               i_vm_porch,
  input  logic [VW-1:0]               i_vm_synch,
  input  logic [VW-1:0]               i_vm_raw,
  input  logic [3*BITS_PER_COLOR-1:0] i_pixel,
  output logic                        o_rd,
  output logic                        o_newline,
  output logic                        o_newframe,
  output logic                        o_vga_hsync,
  output logic                        o_vga_vsync,
  output logic [BITS_PER_COLOR-1:0]   o_vga_red,
  output logic [BITS_PER_COLOR-1:0]   o_vga_green,
  output logic [BITS_PER_COLOR-1:0]   o_vga_blue,
  output logic                        o_err
`ifdef VGA_SCANOUT_DE_EN
  ,
  output logic                        o_vga_de
`endif
);

  localparam int unsigned BPC = BITS_PER_COLOR;

  logic [HW-1:0] hm_width_q, hm_porch_q, hm_synch_q, hm_raw_q;
  logic [HW-1:0] hm_width_d, hm_porch_d, hm_synch_d, hm_raw_d;
  logic [VW-1:0] vm_height_q, vm_porch_q, vm_synch_q, vm_raw_q;
  logic [VW-1:0] vm_height_d, vm_porch_d, vm_synch_d, vm_raw_d;

  logic cfg_ok, cfg_ok_d, cfg_latch, frame_end, run, go;
  logic h_last, h_active_nxt, h_sync_nxt, h_last_nxt;
  logic v_last, v_active_nxt, v_sync_nxt, v_last_nxt;

  assign cfg_ok = axis_cfg_ok(32'(hm_width_q), 32'(hm_porch_q), 32'(hm_synch_q), 32'(hm_raw_q))
               && axis_cfg_ok(32'(vm_height_q), 32'(vm_porch_q), 32'(vm_synch_q),
                              32'(vm_raw_q));

  assign frame_end = cfg_ok & h_last & v_last;
  // An invalid shadow reloads every cycle so a corrected config is picked up without a reset.
  assign cfg_latch = i_reset | ~cfg_ok | frame_end;

  always_comb begin
    hm_width_d  = hm_width_q;
    hm_porch_d  = hm_porch_q;
    hm_synch_d  = hm_synch_q;
    hm_raw_d    = hm_raw_q;
    vm_height_d = vm_height_q;
    vm_porch_d  = vm_porch_q;
    vm_synch_d  = vm_synch_q;
    vm_raw_d    = vm_raw_q;
    if (cfg_latch) begin
      hm_width_d  = i_hm_width;
      hm_porch_d  = i_hm_porch;
      hm_synch_d  = i_hm_synch;
      hm_raw_d    = i_hm_raw;
      vm_height_d = i_vm_height;
      vm_porch_d  = i_vm_porch;
      vm_synch_d  = i_vm_synch;
      vm_raw_d    = i_vm_raw;
    end
  end

  assign cfg_ok_d = axis_cfg_ok(32'(hm_width_d), 32'(hm_porch_d), 32'(hm_synch_d), 32'(hm_raw_d))
                 && axis_cfg_ok(32'(vm_height_d), 32'(vm_porch_d), 32'(vm_synch_d),
                                32'(vm_raw_d));

  always_ff @(posedge i_pixclk) begin
    hm_width_q  <= hm_width_d;
    hm_porch_q  <= hm_porch_d;
    hm_synch_q  <= hm_synch_d;
    hm_raw_q    <= hm_raw_d;
    vm_height_q <= vm_height_d;
    vm_porch_q  <= vm_porch_d;
    vm_synch_q  <= vm_synch_d;
    vm_raw_q    <= vm_raw_d;
  end

  assign run = cfg_ok & ~i_reset;
  assign go  = cfg_ok_d & ~i_reset;

  vga_axis_counter #(
    .W (HW)
  ) u_h_axis (
    .clk        (i_pixclk),
    .reset      (i_reset),
    .run        (run),
    .step       (1'b1),
    .raw        (hm_raw_q),
    .dec_size   (hm_width_d),
    .dec_porch  (hm_porch_d),
    .dec_synch  (hm_synch_d),
    .dec_raw    (hm_raw_d),
    .last       (h_last),
    .active_nxt (h_active_nxt),
    .sync_nxt   (h_sync_nxt),
    .last_nxt   (h_last_nxt)
  );

  vga_axis_counter #(
    .W (VW)
  ) u_v_axis (
    .clk        (i_pixclk),
    .reset      (i_reset),
    .run        (run),
    .step       (h_last),
    .raw        (vm_raw_q),
    .dec_size   (vm_height_d),
    .dec_porch  (vm_porch_d),
    .dec_synch  (vm_synch_d),
    .dec_raw    (vm_raw_d),
    .last       (v_last),
    .active_nxt (v_active_nxt),
    .sync_nxt   (v_sync_nxt),
    .last_nxt   (v_last_nxt)
  );

  // Stage 0 is aligned with the counters; stage 2 drives the pins.
  logic           rd_q, newline_q, newframe_q;
  logic           hs0_q, vs0_q, hs1_q, vs1_q, hs2_q, vs2_q;
  logic           act1_q;
  logic [3*BPC-1:0] rgb_q;

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      rd_q       <= 1'b0;
      newline_q  <= 1'b0;
      newframe_q <= 1'b0;
      hs0_q      <= ~SYNC_ACTIVE;
      vs0_q      <= ~SYNC_ACTIVE;
      hs1_q      <= ~SYNC_ACTIVE;
      vs1_q      <= ~SYNC_ACTIVE;
      hs2_q      <= ~SYNC_ACTIVE;
      vs2_q      <= ~SYNC_ACTIVE;
      act1_q     <= 1'b0;
      rgb_q      <= '0;
    end else begin
      rd_q       <= go & h_active_nxt & v_active_nxt;
      newline_q  <= go & h_last_nxt;
      newframe_q <= go & h_last_nxt & v_last_nxt;
      hs0_q      <= go ? h_sync_nxt : ~SYNC_ACTIVE;
      vs0_q      <= go ? v_sync_nxt : ~SYNC_ACTIVE;
      hs1_q      <= hs0_q;
      vs1_q      <= vs0_q;
      hs2_q      <= hs1_q;
      vs2_q      <= vs1_q;
      act1_q     <= rd_q;
      rgb_q      <= act1_q ? i_pixel : '0;
    end
  end

  assign o_rd        = rd_q;
  assign o_newline   = newline_q;
  assign o_newframe  = newframe_q;
  assign o_vga_hsync = hs2_q;
  assign o_vga_vsync = vs2_q;
  assign o_vga_red   = rgb_q[3*BPC-1 -: BPC];
  assign o_vga_green = rgb_q[2*BPC-1 -: BPC];
  assign o_vga_blue  = rgb_q[BPC-1:0];
  assign o_err       = ~cfg_ok;

`ifdef VGA_SCANOUT_DE_EN
  logic de_q;

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      de_q <= 1'b0;
    end else begin
      de_q <= act1_q;
    end
  end

  assign o_vga_de = de_q;
`else
  // Without the data-enable pin, blanking is visible only as RGB forced to zero.
`endif

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter BITS_PER_COLOR, default 4: bits per colour channel (BPC); a pixel is 3*BPC bits, red in the MSBs and blue in the LSBs.
REQ-002 SHALL have parameter HW, default 12: horizontal counter and config width.
REQ-003 SHALL have parameter VW, default 12: vertical counter and config width.
REQ-004 SHALL have port i_pixclk  in  1  pixel clock; the block has one clock.
REQ-005 SHALL have port i_reset  in  1  synchronous active-high reset.
REQ-006 SHALL have ports i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw  in  HW each  horizontal active width, sync start, sync end and total count.
REQ-007 SHALL have ports i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw  in  VW each  vertical equivalents of REQ-006.
REQ-008 SHALL have port i_pixel  in  3*BPC  pixel returned by the pixel source.
REQ-009 SHALL have port o_rd  out  1  pixel request to the source.
REQ-010 SHALL have ports o_newline and o_newframe  out  1 each  one-cycle strobes to the source.
REQ-011 SHALL have ports o_vga_hsync and o_vga_vsync  out  1 each  sync outputs, active low.
REQ-012 SHALL have ports o_vga_red, o_vga_green, o_vga_blue  out  BPC each  colour outputs.
REQ-013 SHALL have port o_err  out  1  the latched timing config is invalid.

Function
REQ-014 SHALL latch all eight config inputs into shadow registers at reset and on the final cycle of each frame; mid-frame config changes take effect at the next frame.
REQ-015 SHALL treat the config as valid only when width<porch<synch<raw and height<porch<synch<raw hold on the respective axis, and both width and height are nonzero.
REQ-016 SHALL, while the shadow config is invalid, drive o_err=1, hold both counters at 0, and drive o_rd, o_newline and o_newframe to 0, both syncs to 1 and RGB to 0.
REQ-017 SHALL count hpos from 0 to raw-1 and then wrap to 0; vpos SHALL increment on each hpos wrap and wrap to 0 after vm_raw-1.
REQ-018 SHALL assert o_rd combinationally-free, as a registered output, for exactly the cycles where hpos<width and vpos<height.
REQ-019 SHALL pulse o_newline for one cycle when hpos==raw-1 on every line, including blanking lines.
REQ-020 SHALL pulse o_newframe coincident with o_newline when vpos==vm_raw-1.
REQ-021 SHALL, since the source returns i_pixel one cycle after o_rd, register i_pixel onto RGB one cycle later; hsync, vsync and the active flag SHALL be delayed so that RGB, syncs and blanking all refer to the same (hpos,vpos), with two cycles of latency from counter to pins.
REQ-022 SHALL drive RGB to 0 outside the active region, whatever i_pixel holds.
REQ-023 SHALL drive hsync low exactly for porch<=hpos<synch and vsync low exactly for porch<=vpos<synch, pin-aligned per REQ-021.

Reset
REQ-024 SHALL, on i_reset, drive hpos=0, vpos=0, o_rd=0, o_newline=0, o_newframe=0, syncs=1, RGB=0 and clear the pipeline; the shadow config SHALL load from the inputs and o_err SHALL reflect it one cycle later.
REQ-025 SHALL, on reset mid-frame, resume with a full frame starting at hpos=0, vpos=0, and SHALL issue no o_newframe pulse until that frame ends.

Configuration
REQ-026 SHALL, with VGA_SCANOUT_DE_EN defined, add output o_vga_de (1 bit, high on pin-aligned active pixels, reset 0); without the macro the port is absent and behaviour is otherwise identical.

Structure
REQ-027 SHALL take the BPC, HW and VW defaults and the sync-polarity constant from shared package vga_pkg.
REQ-028 SHALL implement each axis with one sub-module, vga_axis_counter (count, wrap, active and sync decode), instantiated twice.

Verification
REQ-029 SHALL verify: h=4/5/6/8, v=2/3/4/5 -> o_rd high 4 cycles per line on lines 0-1 only, o_newline every 8 cycles, o_newframe every 40 cycles.
REQ-030 SHALL verify: 640/656/752/800, 480/490/492/525 -> 307200 o_rd cycles per frame, hsync low 96 cycles, vsync low 2 lines, frame length 420000 cycles.
REQ-031 SHALL verify: the source echoes i_pixel=hpos one cycle after o_rd -> RGB shows 0,1,2,3 in the first four active pin cycles and 0 during blanking, with hsync aligned.
REQ-032 SHALL verify: i_hm_porch changes mid-frame -> timing is unchanged until the cycle after o_newframe, after which the new sync position applies.
REQ-033 SHALL verify: config with width=porch -> o_err=1, o_rd=0, syncs=1; restoring a valid config -> normal frames resume after the next latch.
REQ-034 SHALL verify: i_reset pulsed at hpos=3, vpos=1 -> next cycle all outputs are at reset values, and the first o_newframe arrives after 40 cycles.
